serial_add_scheduler: RTL and testbench

Shares one serial_adder instance between two requesters.
- Arbitrates requests round-robin and loads the winner's operands into the adder.
- Pulses the adder's restart, counts the bit-serial latency, then captures sum and carry.
- Returns the result with the requester ID over a valid/ready response port.
- Sits between client logic and the serial_adder datapath. All adder sequencing lives here.

---
 rtl/serial_add_pkg.sv | 21 ++
 rtl/serial_add_scheduler_rr_arbiter2.sv | 42 ++++
 rtl/serial_add_scheduler.sv | 124 ++++++++++++
 tb/tb_serial_add_scheduler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder scheduler.
package serial_add_pkg;

  localparam int WIDTH_DEFAULT       = 16;
  localparam int ADD_LATENCY_DEFAULT = 16;
  localparam int CNT_W_DEFAULT       = $clog2(ADD_LATENCY_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef logic req_id_t;

  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/serial_add_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances past the winner on accept.
module rr_arbiter2
  import serial_add_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_valid_i,
  output logic [1:0] grant_o,
  output logic       accept_o,
  output req_id_t    accept_id_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      case (req_valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // A grant is only ever raised on a valid requester, so grant alone is the handshake.
  assign accept_o    = |grant_o;
  assign accept_id_o = grant_o[1];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_o) rr_ptr_d = ~accept_id_o;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Time-shares one bit-serial adder between two requesters: arbitrate, load, run, respond.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int ADD_LATENCY = ADD_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_reset,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int CNT_W = cnt_width(ADD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_LATENCY - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  req_id_t          res_id_q, res_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             arb_en;
  logic             accept;
  req_id_t          accept_id;

  // Requests are only considered in IDLE and never while reset is held.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .en_i        (arb_en),
    .req_valid_i (req_valid),
    .grant_o     (req_ready),
    .accept_o    (accept),
    .accept_id_o (accept_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      add_a_q    <= '0;
      add_b_q    <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_id_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_id_q   <= res_id_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_id_d   = res_id_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          add_a_d  = accept_id ? req1_a : req0_a;
          add_b_d  = accept_id ? req1_b : req0_b;
          res_id_d = accept_id;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // The adder output settles in the last counted cycle; sample it there.
        if (cnt_q == CNT_LAST) begin
          res_sum_d  = add_sum;
          res_cout_d = add_cout;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == RESP);
    add_reset = reset || (state_q == LOAD);
    add_a     = add_a_q;
    add_b     = add_b_q;
    res_sum   = res_sum_q;
    res_cout  = res_cout_q;
    res_id    = res_id_q;
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler with a behavioural latency-accurate adder and a queue-based result model.
module tb_serial_add_scheduler;

  localparam int WIDTH = 16;
  localparam int LAT   = 16;

  typedef struct packed {
    logic             id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             res_valid, res_ready, res_cout, res_id, busy;
  logic [WIDTH-1:0] res_sum, add_a, add_b, add_sum;
  logic             add_reset, add_cout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_add_scheduler #(.WIDTH(WIDTH), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .busy(busy), .add_a(add_a),
    .add_b(add_b), .add_reset(add_reset), .add_sum(add_sum), .add_cout(add_cout)
  );

  // Adder stand-in: correct result only once LAT cycles have elapsed since restart, inverted before.
  logic [7:0]       acnt;
  logic [WIDTH:0]   afull;
  always_ff @(posedge clk) begin
    if (add_reset)          acnt <= 8'd0;
    else if (acnt != 8'hFF) acnt <= acnt + 8'd1;
  end
  assign afull    = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum  = (acnt >= 8'(LAT - 1)) ? afull[WIDTH-1:0] : ~afull[WIDTH-1:0];
  assign add_cout = (acnt >= 8'(LAT - 1)) ? afull[WIDTH] : ~afull[WIDTH];

  function automatic exp_t model_add(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b};
    return '{id: id, cout: full[WIDTH], sum: full[WIDTH-1:0]};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    repeat (2) next_cycle;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    next_cycle;
    @(negedge clk);
    vectors++;
    if ({busy, res_valid, res_sum, res_cout, res_id, add_a, add_b, add_reset, req_ready} !==
        {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b rv=%b sum=%h co=%b id=%b a=%h b=%h ar=%b rdy=%b required 0 0 0000 0 0 0000 0000 1 00",
               busy, res_valid, res_sum, res_cout, res_id, add_a, add_b, add_reset, req_ready);
    end
    next_cycle;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01 || add_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_tie: req_ready=%b add_reset=%b required 01 0", req_ready, add_reset);
    end
    req_valid = 2'b00;
    next_cycle;
  endtask

  task automatic test_single(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] esum, input logic ecout);
    logic [1:0] vreq;
    int lat;
    do_reset;
    vreq = id ? 2'b10 : 2'b01;
    req0_a = id ? 16'h1111 : a;  req0_b = id ? 16'h2222 : b;
    req1_a = id ? a : 16'h3333;  req1_b = id ? b : 16'h4444;
    req_valid = vreq;
    res_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== vreq) begin
      miscompares++;
      $display("FAIL single%0d_ready: got %b required %b", id, req_ready, vreq);
    end
    next_cycle;
    req_valid = 2'b00;
    @(negedge clk);
    vectors++;
    if (add_reset !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single%0d_load: add_reset=%b busy=%b required 1 1", id, add_reset, busy);
    end
    next_cycle;
    @(negedge clk);
    vectors++;
    if (add_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL single%0d_restart_pulse: add_reset=%b required 0", id, add_reset);
    end
    lat = -1;
    for (int k = 2; k < 40; k++) begin
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
      next_cycle;
      @(negedge clk);
    end
    vectors++;
    if (lat != 18 || res_sum !== esum || res_cout !== ecout || res_id !== id) begin
      miscompares++;
      $display("FAIL single%0d_result: lat=%0d sum=%h cout=%b id=%b required lat=18 sum=%h cout=%b id=%b",
               id, lat, res_sum, res_cout, res_id, esum, ecout, id);
    end
    next_cycle;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single%0d_drain: busy=%b res_valid=%b required 0 0", id, busy, res_valid);
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e;
    int acc_cyc[$];
    logic acc_id[$];
    logic m_idle, m_rr;
    logic [1:0] er;
    do_reset;
    m_idle = 1'b1;
    m_rr = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      @(negedge clk);
      er = m_idle ? (m_rr ? 2'b10 : 2'b01) : 2'b00;
      vectors++;
      if (req_ready !== er) begin
        miscompares++;
        $display("FAIL b2b_ready c%0d: got %b required %b", c, req_ready, er);
      end
      if (res_valid === 1'b1) begin
        vectors++;
        e = (q.size() != 0) ? q.pop_front() : '0;
        if ({res_id, res_cout, res_sum} !== e) begin
          miscompares++;
          $display("FAIL b2b_result c%0d: got id=%b co=%b sum=%h required id=%b co=%b sum=%h",
                   c, res_id, res_cout, res_sum, e.id, e.cout, e.sum);
        end
        m_idle = 1'b1;
      end
      if (req_ready == 2'b01 || req_ready == 2'b10) begin
        acc_cyc.push_back(c);
        acc_id.push_back(req_ready[1]);
        q.push_back(req_ready[1] ? model_add(1'b1, req1_a, req1_b) : model_add(1'b0, req0_a, req0_b));
        m_idle = 1'b0;
        m_rr = ~req_ready[1];
      end
      next_cycle;
    end
    req_valid = 2'b00;
    vectors++;
    if (acc_cyc.size() != 6) begin
      miscompares++;
      $display("FAIL b2b_accept_count: got %0d required 6", acc_cyc.size());
    end
    for (int i = 0; i < acc_cyc.size(); i++) begin
      vectors++;
      if (acc_id[i] !== i[0] || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != LAT + 3)) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: id=%b gap=%0d required id=%b gap=%0d", i, acc_id[i],
                 (i > 0) ? acc_cyc[i] - acc_cyc[i-1] : 0, i[0], LAT + 3);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int wait_c;
    do_reset;
    req1_a = 16'($urandom); req1_b = 16'($urandom);
    e = model_add(1'b1, req1_a, req1_b);
    req_valid = 2'b10;
    res_ready = 1'b0;
    next_cycle;
    req_valid = 2'b00;
    wait_c = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && wait_c < 40) begin
      next_cycle;
      @(negedge clk);
      wait_c++;
    end
    req_valid = 2'b11;
    req0_a = 16'($urandom); req1_a = 16'($urandom);
    for (int c = 0; c < 10; c++) begin
      next_cycle;
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b1 || {res_id, res_cout, res_sum} !== e || req_ready !== 2'b00 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: rv=%b id=%b co=%b sum=%h rdy=%b busy=%b required 1 %b %b %h 00 1",
                 c, res_valid, res_id, res_cout, res_sum, req_ready, busy, e.id, e.cout, e.sum);
      end
    end
    res_ready = 1'b1;
    next_cycle;
    res_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: busy=%b rv=%b rdy=%b required 0 0 01", busy, res_valid, req_ready);
    end
    req_valid = 2'b00;
    next_cycle;
  endtask

  task automatic test_operand_change;
    int wait_c;
    do_reset;
    req0_a = 16'h1234; req0_b = 16'h0F0F;
    req_valid = 2'b01;
    res_ready = 1'b1;
    next_cycle;
    req_valid = 2'b00;
    repeat (2) next_cycle;
    req0_a = 16'h0001; req0_b = 16'hFFFF;
    @(negedge clk);
    vectors++;
    if (add_a !== 16'h1234 || add_b !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL opchg_hold: add_a=%h add_b=%h required 1234 0f0f", add_a, add_b);
    end
    wait_c = 0;
    while (res_valid !== 1'b1 && wait_c < 40) begin
      next_cycle;
      @(negedge clk);
      wait_c++;
    end
    vectors++;
    if (res_valid !== 1'b1 || res_sum !== 16'h2143 || res_cout !== 1'b0 || res_id !== 1'b0) begin
      miscompares++;
      $display("FAIL opchg_result: rv=%b sum=%h co=%b id=%b required 1 2143 0 0", res_valid, res_sum, res_cout, res_id);
    end
    next_cycle;
  endtask

  task automatic test_reset_midrun;
    exp_t e;
    int nres;
    do_reset;
    req0_a = 16'hAAAA; req0_b = 16'h5555;
    req_valid = 2'b01;
    res_ready = 1'b1;
    next_cycle;
    req_valid = 2'b00;
    repeat (6) next_cycle;
    reset = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (add_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_add_reset: got %b required 1", add_reset);
    end
    next_cycle;
    reset = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_abort: busy=%b res_valid=%b required 0 0", busy, res_valid);
    end
    req0_a = 16'h0102; req0_b = 16'h0304;
    req1_a = 16'h7777; req1_b = 16'h8888;
    e = model_add(1'b0, req0_a, req0_b);
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL midrun_rr_ptr: req_ready=%b required 01", req_ready);
    end
    next_cycle;
    req_valid = 2'b00;
    res_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        nres++;
        vectors++;
        if ({res_id, res_cout, res_sum} !== e) begin
          miscompares++;
          $display("FAIL midrun_result: id=%b co=%b sum=%h required %b %b %h", res_id, res_cout, res_sum, e.id, e.cout, e.sum);
        end
      end
      next_cycle;
    end
    vectors++;
    if (nres != 1) begin
      miscompares++;
      $display("FAIL midrun_result_count: got %0d required 1", nres);
    end
  endtask

  task automatic test_random;
    exp_t q[$];
    exp_t e;
    logic m_idle, m_rr;
    logic [1:0] er;
    int c;
    do_reset;
    m_idle = 1'b1;
    m_rr = 1'b0;
    c = 0;
    while (c < 700 && (c < 600 || q.size() != 0)) begin
      req_valid = (c < 600) ? 2'($urandom) : 2'b00;
      res_ready = (c < 600) ? 1'($urandom) : 1'b1;
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      @(negedge clk);
      case (req_valid)
        2'b01:   er = 2'b01;
        2'b10:   er = 2'b10;
        2'b11:   er = m_rr ? 2'b10 : 2'b01;
        default: er = 2'b00;
      endcase
      if (!m_idle) er = 2'b00;
      vectors++;
      if (req_ready !== er) begin
        miscompares++;
        $display("FAIL rand_ready c%0d: got %b required %b", c, req_ready, er);
      end
      if (res_valid === 1'b1) begin
        vectors++;
        e = (q.size() != 0) ? q[0] : '0;
        if (q.size() == 0 || {res_id, res_cout, res_sum} !== e) begin
          miscompares++;
          $display("FAIL rand_result c%0d: got id=%b co=%b sum=%h required id=%b co=%b sum=%h pending=%0d",
                   c, res_id, res_cout, res_sum, e.id, e.cout, e.sum, q.size());
        end
        if (res_ready && q.size() != 0) begin
          void'(q.pop_front());
          m_idle = 1'b1;
        end
      end
      if (er != 2'b00) begin
        q.push_back(er[1] ? model_add(1'b1, req1_a, req1_b) : model_add(1'b0, req0_a, req0_b));
        m_idle = 1'b0;
        m_rr = ~er[1];
      end
      next_cycle;
      c++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain_timeout: %0d results outstanding required 0", q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #1;
    test_reset;
    test_single(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
    test_single(1'b1, 16'h500A, 16'h400A, 16'h9014, 1'b0);
    test_back_to_back;
    test_backpressure;
    test_operand_change;
    test_reset_midrun;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
